// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: frame-level sequencer for a streaming KxK median filter.
// It tracks the raster position of incoming pixels and flags complete windows
// to the median core. It also regenerates the core's result strobe after LAT
// cycles, supplies output coordinates and reports frame completion.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   start_i      arm for one frame (honoured only in IDLE)
//   done_i       input pixel valid
//   busy_o       high while a frame is in progress (RUN or DRAIN)
//   win_valid_o  one-cycle strobe per pixel that completes a WIN x WIN window
//   done_o       median result valid (win_valid_o delayed LAT cycles)
//   out_col_o    output column of the result flagged by done_o
//   out_row_o    output row of the result flagged by done_o
//   frame_done_o pulse with the last done_o of a frame
//   err_o        sticky protocol error (pixel outside RUN)
//
// Optional build macro: MEDIAN_FRAME_CTRL_AUTO_RESTART_EN
//   defined   -> after frame_done_o the FSM re-enters RUN with counters cleared
//   undefined -> the FSM returns to IDLE and waits for start_i
module median_frame_ctrl #(
  parameter int unsigned IMG_W = 9,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN   = 3,
  parameter int unsigned LAT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     done_i,
  output logic                     busy_o,
  output logic                     win_valid_o,
  output logic                     done_o,
  output logic [$clog2(IMG_W)-1:0] out_col_o,
  output logic [$clog2(IMG_H)-1:0] out_row_o,
  output logic                     frame_done_o,
  output logic                     err_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [CW-1:0]  in_col, in_col_nxt;
  logic [RW-1:0]  in_row, in_row_nxt;
  logic [CW-1:0]  out_col_nxt;
  logic [RW-1:0]  out_row_nxt;
  logic [LAT-1:0] vld_sr, vld_nxt;
  logic           err_nxt, win_nxt, busy_nxt, frame_done_nxt, done_nxt, clr_out;

  // Result strobe leaves the end of the delay line as a flop output.
  assign done_o = vld_sr[LAT-1];

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_col       <= '0;
      in_row       <= '0;
      out_col_o    <= '0;
      out_row_o    <= '0;
      vld_sr       <= '0;
      err_o        <= 1'b0;
      win_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_col       <= in_col_nxt;
      in_row       <= in_row_nxt;
      out_col_o    <= out_col_nxt;
      out_row_o    <= out_row_nxt;
      vld_sr       <= vld_nxt;
      err_o        <= err_nxt;
      win_valid_o  <= win_nxt;
      busy_o       <= busy_nxt;
      frame_done_o <= frame_done_nxt;
    end
  end

  // Next-state, input position tracking and output-side bookkeeping.
  always_comb begin
    state_nxt  = state;
    in_col_nxt = in_col;
    in_row_nxt = in_row;
    err_nxt    = err_o;
    win_nxt    = 1'b0;
    clr_out    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          // start wins over a coincident pixel, which is dropped silently
          state_nxt  = S_RUN;
          in_col_nxt = '0;
          in_row_nxt = '0;
          err_nxt    = 1'b0;
          clr_out    = 1'b1;
        end else if (done_i) begin
          err_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (done_i) begin
          win_nxt = (in_row >= RW'(WIN - 1)) && (in_col >= CW'(WIN - 1));
          if (in_col == CW'(IMG_W - 1)) begin
            in_col_nxt = '0;
            if (in_row == RW'(IMG_H - 1)) begin
              in_row_nxt = '0;
              state_nxt  = S_DRAIN;
            end else begin
              in_row_nxt = in_row + RW'(1);
            end
          end else begin
            in_col_nxt = in_col + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (done_i) begin
          err_nxt = 1'b1;
        end
        // frame_done_o marks the final result: the delay line is empty now
        if (frame_done_o) begin
`ifdef MEDIAN_FRAME_CTRL_AUTO_RESTART_EN
          state_nxt  = S_RUN;
          in_col_nxt = '0;
          in_row_nxt = '0;
          clr_out    = 1'b1;
`else
          state_nxt  = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Output coordinates step past each result once it has been presented.
    out_col_nxt = out_col_o;
    out_row_nxt = out_row_o;
    if (clr_out) begin
      out_col_nxt = '0;
      out_row_nxt = '0;
    end else if (done_o) begin
      if (out_col_o == CW'(IMG_W - WIN)) begin
        out_col_nxt = '0;
        out_row_nxt = (out_row_o == RW'(IMG_H - WIN)) ? '0 : out_row_o + RW'(1);
      end else begin
        out_col_nxt = out_col_o + CW'(1);
      end
    end

    vld_nxt  = (vld_sr << 1) | LAT'(win_valid_o);
    done_nxt = vld_nxt[LAT-1];

    // Look at the coordinates that will accompany the next done_o.
    frame_done_nxt = done_nxt && (out_row_nxt == RW'(IMG_H - WIN)) &&
                     (out_col_nxt == CW'(IMG_W - WIN));
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl: a schedule-based model predicts every output
// per cycle from the accepted pixel stream, and directed frames pin counts,
// latency and error behaviour with hand-computed values.
module tb_median_frame_ctrl;

  localparam int unsigned IMG_W = 9;
  localparam int unsigned IMG_H = 9;
  localparam int unsigned WIN   = 3;
  localparam int unsigned LAT   = 4;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic rst, start_i, done_i;
  logic busy_o, win_valid_o, done_o, frame_done_o, err_o;
  logic [$clog2(IMG_W)-1:0] out_col_o;
  logic [$clog2(IMG_H)-1:0] out_row_o;

  median_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .done_i(done_i),
    .busy_o(busy_o), .win_valid_o(win_valid_o), .done_o(done_o),
    .out_col_o(out_col_o), .out_row_o(out_row_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: frame active, pixels taken, cycle of the final result
  bit m_act, m_err;
  int m_n, m_end;
  bit exp_win [MAXC];
  bit exp_done[MAXC];
  bit exp_fd  [MAXC];
  bit exp_busy[MAXC];
  bit exp_err [MAXC];
  int exp_r   [MAXC];
  int exp_c   [MAXC];

  // observation records
  int res_cnt = 0;
  int fd_cnt = 0;
  int last_r = -1;
  int last_c = -1;
  int done_cyc[1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: every accepted pixel that closes a window produces a strobe this
  // cycle and a result LAT cycles later at its window's top-left position.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc + LAT + 2 < MAXC) begin
      if (!rst) begin
        m_act = 0;
        m_err = 0;
        m_n   = 0;
        for (int i = 0; i <= LAT + 1; i++) begin
          exp_win[cyc+i]  = 0;
          exp_done[cyc+i] = 0;
          exp_fd[cyc+i]   = 0;
        end
      end else if (!m_act) begin
        if (start_i) begin
          m_act = 1;
          m_err = 0;
          m_n   = 0;
          m_end = MAXC;
        end else if (done_i) begin
          m_err = 1;
        end
      end else if (m_n < TOTAL) begin
        if (done_i) begin
          int r, c;
          r = m_n / IMG_W;
          c = m_n % IMG_W;
          if (r >= WIN - 1 && c >= WIN - 1) begin
            exp_win[cyc]      = 1;
            exp_done[cyc+LAT] = 1;
            exp_r[cyc+LAT]    = r - (WIN - 1);
            exp_c[cyc+LAT]    = c - (WIN - 1);
          end
          if (m_n == TOTAL - 1) begin
            exp_fd[cyc+LAT] = 1;
            m_end = cyc + LAT;
          end
          m_n++;
        end
      end else begin
        if (done_i) m_err = 1;
        if (cyc > m_end) m_act = 0;
      end
      exp_busy[cyc] = m_act;
      exp_err[cyc]  = m_err;
    end
  end

  // Per-cycle comparison against the model, plus result bookkeeping.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      chk("win_valid", win_valid_o, exp_win[cyc]);
      chk("done", done_o, exp_done[cyc]);
      chk("frame_done", frame_done_o, exp_fd[cyc]);
      chk("busy", busy_o, exp_busy[cyc]);
      chk("err", err_o, exp_err[cyc]);
      if (exp_done[cyc]) begin
        chk("out_col", out_col_o, exp_c[cyc]);
        chk("out_row", out_row_o, exp_r[cyc]);
      end
      if (done_o === 1'b1) begin
        if (res_cnt < 1024) done_cyc[res_cnt] = cyc;
        res_cnt++;
      end
      if (frame_done_o === 1'b1) begin
        fd_cnt++;
        last_r = out_row_o;
        last_c = out_col_o;
      end
    end
  end

  task automatic drive(input logic s, input logic d);
    start_i = s;
    done_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // n pixels; with gaps set, every third cycle carries no pixel
  task automatic pixels(input int n, input bit gaps);
    int sent, j;
    sent = 0;
    j = 0;
    while (sent < n) begin
      if (gaps && (j % 3 == 2)) drive(1'b0, 1'b0);
      else begin
        drive(1'b0, 1'b1);
        sent++;
      end
      j++;
    end
    done_i = 1'b0;
  endtask

  task automatic wait_frame(input int fd_base);
    for (int i = 0; i < 40 && fd_cnt == fd_base; i++) drive(1'b0, 1'b0);
    chk("frame_done_seen", (fd_cnt != fd_base), 1);
    idle(3);
  endtask

  initial begin
    int b, f, sc;
    rst = 1'b0;
    start_i = 1'b0;
    done_i = 1'b0;
    idle(2);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    rst = 1'b1;
    idle(2);

    // continuous frame
    b = res_cnt; f = fd_cnt;
    drive(1'b1, 1'b0);
    sc = cyc;
    pixels(TOTAL, 1'b0);
    wait_frame(f);
    chk("t1_results", res_cnt - b, 49);
    chk("t1_first_latency", done_cyc[b] - sc, 25);
    chk("t1_last_latency", done_cyc[b+48] - sc, 85);
    chk("t1_last_row", last_r, 6);
    chk("t1_last_col", last_c, 6);
    chk("t1_busy_after", busy_o, 0);
    chk("t1_err", err_o, 0);

    // frame with a gap every third cycle
    b = res_cnt; f = fd_cnt;
    drive(1'b1, 1'b0);
    pixels(TOTAL, 1'b1);
    wait_frame(f);
    chk("t2_results", res_cnt - b, 49);

    // pixels with no start, then start clears the error
    b = res_cnt;
    pixels(3, 1'b0);
    chk("t3_err_set", err_o, 1);
    chk("t3_no_results", res_cnt - b, 0);
    drive(1'b1, 1'b0);
    chk("t3_err_cleared", err_o, 0);

    // mid-frame reset after 40 pixels
    pixels(40, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    chk("t4_busy", busy_o, 0);
    chk("t4_win", win_valid_o, 0);
    chk("t4_done", done_o, 0);
    chk("t4_fd", frame_done_o, 0);
    chk("t4_col", out_col_o, 0);
    chk("t4_row", out_row_o, 0);
    rst = 1'b1;
    b = res_cnt;
    idle(10);
    chk("t4_no_stale_done", res_cnt - b, 0);
    b = res_cnt; f = fd_cnt;
    drive(1'b1, 1'b0);
    pixels(TOTAL, 1'b0);
    wait_frame(f);
    chk("t4_results", res_cnt - b, 49);

    // start in RUN ignored, extra pixel in DRAIN flags an error
    b = res_cnt; f = fd_cnt;
    drive(1'b1, 1'b0);
    pixels(30, 1'b0);
    drive(1'b1, 1'b1);
    chk("t5_start_in_run_err", err_o, 0);
    pixels(TOTAL - 31, 1'b0);
    chk("t5_err_before_extra", err_o, 0);
    drive(1'b0, 1'b1);
    chk("t5_err_extra", err_o, 1);
    done_i = 1'b0;
    wait_frame(f);
    chk("t5_results", res_cnt - b, 49);

    // start with a coincident pixel in IDLE: start wins, pixel dropped
    b = res_cnt; f = fd_cnt;
    drive(1'b1, 1'b1);
    chk("t6_err_cleared", err_o, 0);
    chk("t6_busy", busy_o, 1);
    pixels(TOTAL, 1'b0);
    wait_frame(f);
    chk("t6_results", res_cnt - b, 49);
    chk("t6_err", err_o, 0);

    // second frame without start
    b = res_cnt; f = fd_cnt;
    pixels(TOTAL, 1'b0);
    idle(LAT + 3);
    chk("t7_err", err_o, 1);
    chk("t7_no_results", res_cnt - b, 0);
    chk("t7_no_frame_done", fd_cnt - f, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_frame_ctrl.md
Name: median_frame_ctrl

Overview:
- Frame-level sequencer for the streaming KxK median filter datapath.
- Accepts a raster-order grayscale pixel stream qualified by done_i and tracks row/column position.
- Tells the median core when the current pixel completes a full window (win_valid_o), and regenerates the output-valid strobe after the core's fixed latency.
- Supplies output coordinates for writeback and reports frame completion. Sits between the pixel source and the median core plus its result sink.

Parameters:
- IMG_W, 9, frame width in pixels (>= WIN)
- IMG_H, 9, frame height in pixels (>= WIN)
- WIN, 3, window size; output frame is (IMG_W-WIN+1) x (IMG_H-WIN+1)
- LAT, 4, median core latency in cycles from window accept to result (>= 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- start_i  in  1  arm controller for one frame; honoured only in IDLE
- done_i  in  1  input pixel valid; one pixel accepted per cycle when high in RUN
- busy_o  out  1  high in RUN and DRAIN
- win_valid_o  out  1  window-complete strobe to the median core
- done_o  out  1  median result valid, aligned to the core's median_o
- out_col_o  out  $clog2(IMG_W)  output column of the current done_o result
- out_row_o  out  $clog2(IMG_H)  output row of the current done_o result
- frame_done_o  out  1  one-cycle pulse with the last done_o of a frame
- err_o  out  1  sticky protocol error; cleared by reset or accepted start_i

Behaviour:
- Reset (rst=0 at clock edge) takes effect immediately regardless of state. It forces IDLE and zeroes all outputs, counters and the LAT-deep valid delay line. No stale done_o may appear after a mid-frame reset.
- IDLE:
  - start_i=1 -> RUN; in_col, in_row, out_col, out_row and err_o are cleared.
  - done_i=1 while in IDLE sets err_o; the pixel is ignored.
- RUN:
  - Each done_i=1 cycle accepts one pixel at (in_row, in_col).
  - in_col wraps IMG_W-1 -> 0 and increments in_row.
  - done_i=0 cycles hold all counters; gaps of any length are legal.
  - When the accepted pixel has in_row >= WIN-1 and in_col >= WIN-1, win_valid_o is driven high in the next cycle, for exactly one cycle per such pixel.
  - Accepting pixel IMG_W*IMG_H-1 -> DRAIN.
- DRAIN:
  - Waits until the valid delay line is empty and the last done_o has been issued.
  - done_i=1 sets err_o; the pixel is ignored.
- Output side:
  - done_o is win_valid_o delayed exactly LAT cycles through a shift register.
  - out_col_o/out_row_o show the coordinates of the result currently flagged by done_o. They advance after each done_o, with out_col wrapping IMG_W-WIN -> 0.
- Completion:
  - frame_done_o is high in the same cycle as the done_o for output (IMG_H-WIN, IMG_W-WIN).
  - Next state is IDLE, with busy_o low from that next cycle.
- Simultaneous events: start_i together with done_i in IDLE -> start is honoured, the pixel is not accepted, and err_o stays 0 (err_o is cleared by the start).
- start_i in RUN or DRAIN is ignored and does not set err_o.
- Counter widths never overflow: all wraps occur at the parameter bounds.

Optional Feature:
- Macro: MEDIAN_FRAME_CTRL_AUTO_RESTART_EN
- Defined: at frame_done_o the FSM goes directly to RUN with counters cleared, so the next frame's first pixel may arrive the following cycle. Back-to-back done_i across the frame boundary sets no error. busy_o stays high.
- Undefined: FSM returns to IDLE after each frame; a new start_i is required.

Test Plan:
- Continuous 9x9 frame, start_i at edge 0, done_i high edges 1..81 -> win_valid_o after edges 21..81 on valid windows (49 strobes); first done_o after edge 25 with out_row=0/out_col=0; 49 done_o total; last done_o plus frame_done_o after edge 85 with out_row=6/out_col=6; busy_o low afterwards; err_o=0.
- Same frame with done_i low every third cycle -> still exactly 49 done_o; each done_o exactly 4 cycles after its win_valid_o; coordinates sequence (0,0)..(6,6) in raster order.
- Pixels with no start_i -> err_o=1, no win_valid_o or done_o. Then start_i -> err_o clears.
- Reset asserted after 40 pixels -> all outputs 0 next cycle, no done_o within the following 10 cycles. A new full frame then yields 49 results.
- Extra pixel in DRAIN and start_i mid-RUN -> err_o=1 for the extra pixel only; result count is unaffected.
- With MEDIAN_FRAME_CTRL_AUTO_RESTART_EN: two 9x9 frames back-to-back with no gap -> 98 done_o, two frame_done_o pulses, err_o=0. Without the macro: a second frame after the first with no new start_i -> err_o=1 and no further outputs.
